// File: rtl/lightgun_pkg.sv
// lightgun_pkg: shared types, widths and arithmetic helpers for the
// light-gun capture block (FSM state, report record, clamp/average math).
package lightgun_pkg;

  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  typedef struct packed {
    logic [HCNT_W-1:0] x;
    logic [VCNT_W-1:0] y;
    logic              hit;
    logic              trig;
  } report_t;

  // Column minus sensor delay, clamped at zero instead of wrapping.
  function automatic logic [HCNT_W-1:0] sat_sub_x(input logic [HCNT_W-1:0] a,
                                                  input logic [7:0]        b);
    logic [HCNT_W-1:0] b_ext;
    b_ext = {{(HCNT_W-8){1'b0}}, b};
    if (a >= b_ext) begin
      return a - b_ext;
    end else begin
      return {HCNT_W{1'b0}};
    end
  endfunction

  // Line minus line delay, clamped at zero instead of wrapping.
  function automatic logic [VCNT_W-1:0] sat_sub_y(input logic [VCNT_W-1:0] a,
                                                  input logic [7:0]        b);
    logic [VCNT_W-1:0] b_ext;
    b_ext = {{(VCNT_W-8){1'b0}}, b};
    if (a >= b_ext) begin
      return a - b_ext;
    end else begin
      return {VCNT_W{1'b0}};
    end
  endfunction

  // (a+b)>>1 without losing the carry.
  function automatic logic [HCNT_W-1:0] avg_x(input logic [HCNT_W-1:0] a,
                                              input logic [HCNT_W-1:0] b);
    return HCNT_W'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  // (a+b)>>1 without losing the carry.
  function automatic logic [VCNT_W-1:0] avg_y(input logic [VCNT_W-1:0] a,
                                              input logic [VCNT_W-1:0] b);
    return VCNT_W'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

endpackage

// File: rtl/lightgun_sensor_filter.sv
// lightgun_sensor_filter: brings SENSOR/TRIGGER into the CLK domain and
// qualifies a hit once MIN_PULSE consecutive in-window pixel samples see
// light. run_start_o marks the first sample of a run (candidate position),
// qualified_o marks the MIN_PULSE-th sample.
import lightgun_pkg::*;

module lightgun_sensor_filter #(
  parameter int unsigned MIN_PULSE = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic sensor_i,
  input  logic trigger_i,
  input  logic arm_i,
  input  logic window_i,
  output logic sens_sync_o,
  output logic trig_sync_o,
  output logic run_start_o,
  output logic qualified_o
);

  localparam logic [3:0] MIN_PULSE_C = 4'(MIN_PULSE);

  logic       sens_meta_q, sens_sync_q;
  logic       trig_meta_q, trig_sync_q;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic       hit_sample_s;
  logic       sample_s;

  // Two-flop synchronizers for the asynchronous sensor and trigger lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sens_meta_q <= 1'b0;
      sens_sync_q <= 1'b0;
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
    end else begin
      sens_meta_q <= sensor_i;
      sens_sync_q <= sens_meta_q;
      trig_meta_q <= trigger_i;
      trig_sync_q <= trig_meta_q;
    end
  end

  assign hit_sample_s = window_i & sens_sync_q;
  assign sample_s     = ce_i & arm_i & hit_sample_s;

  // Run length of consecutive lit samples; any dark sample or disarm restarts it.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (ce_i) begin
      if (!arm_i) begin
        run_cnt_d = 4'd0;
      end else if (hit_sample_s) begin
        if (run_cnt_q != 4'hF) begin
          run_cnt_d = run_cnt_q + 4'd1;
        end else begin
          run_cnt_d = run_cnt_q;
        end
      end else begin
        run_cnt_d = 4'd0;
      end
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Run counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q <= 4'd0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign run_start_o = sample_s & (run_cnt_q == 4'd0);
  assign qualified_o = sample_s & ((run_cnt_q + 4'd1) == MIN_PULSE_C);
  assign sens_sync_o = sens_sync_q;
  assign trig_sync_o = trig_sync_q;

endmodule

// File: rtl/lightgun_capture.sv
// lightgun_capture: measures the raster position of the first qualified
// light-gun hit in each frame, subtracts sensor/line delays and offers one
// report per frame on a valid/ready handshake.
// Optional feature macro: LIGHTGUN_AVG_EN (average consecutive hit positions).
import lightgun_pkg::*;

module lightgun_capture #(
  parameter int unsigned MIN_PULSE = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CE_PIX,
  input  logic              HDE,
  input  logic              VDE,
  input  logic              SENSOR,
  input  logic              TRIGGER,
  input  logic [7:0]        SENSOR_DELAY,
  input  logic [7:0]        LINE_DELAY,
  output logic [HCNT_W-1:0] POS_X,
  output logic [VCNT_W-1:0] POS_Y,
  output logic              POS_HIT,
  output logic              POS_TRIG,
  output logic              POS_VALID,
  input  logic              POS_READY,
  output logic              OVERRUN
);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              hde_prev_q, vde_prev_q;
  logic              vde_rise_s, vde_fall_s, hde_fall_s;

  state_e            state_q, state_d;
  logic              hit_q, hit_d;
  logic              trig_q, trig_d;
  logic              report_s;

  logic [HCNT_W-1:0] cand_x_q;
  logic [VCNT_W-1:0] cand_y_q;

  logic              sens_sync_s, trig_sync_s, run_start_s, qualified_s;
  logic              arm_s;

  logic [HCNT_W-1:0] raw_x_s;
  logic [VCNT_W-1:0] raw_y_s;
  report_t           rep_s;
  report_t           rep_q;
  logic              valid_q, overrun_q;
  logic              load_s;

  assign arm_s = (state_q == ST_ARMED);

  lightgun_sensor_filter #(
    .MIN_PULSE (MIN_PULSE)
  ) u_filter (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .ce_i        (CE_PIX),
    .sensor_i    (SENSOR),
    .trigger_i   (TRIGGER),
    .arm_i       (arm_s),
    .window_i    (HDE & VDE),
    .sens_sync_o (sens_sync_s),
    .trig_sync_o (trig_sync_s),
    .run_start_o (run_start_s),
    .qualified_o (qualified_s)
  );

  assign vde_rise_s = CE_PIX &  VDE & ~vde_prev_q;
  assign vde_fall_s = CE_PIX & ~VDE &  vde_prev_q;
  assign hde_fall_s = CE_PIX & ~HDE &  hde_prev_q;

  // Raster counters: clear outside the display window, count up and saturate.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (CE_PIX) begin
      if (!HDE) begin
        hcnt_d = {HCNT_W{1'b0}};
      end else if (hcnt_q != {HCNT_W{1'b1}}) begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q;
      end
      if (!VDE) begin
        vcnt_d = {VCNT_W{1'b0}};
      end else if (hde_fall_s && (vcnt_q != {VCNT_W{1'b1}})) begin
        vcnt_d = vcnt_q + VCNT_W'(1);
      end else begin
        vcnt_d = vcnt_q;
      end
    end else begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
    end
  end

  // Raster counters and HDE/VDE history. vde_prev resets high so a reset
  // released mid-frame cannot fake a VDE rise and report a partial frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q     <= {HCNT_W{1'b0}};
      vcnt_q     <= {VCNT_W{1'b0}};
      hde_prev_q <= 1'b0;
      vde_prev_q <= 1'b1;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (CE_PIX) begin
        hde_prev_q <= HDE;
        vde_prev_q <= VDE;
      end else begin
        hde_prev_q <= hde_prev_q;
        vde_prev_q <= vde_prev_q;
      end
    end
  end

  // Frame FSM: arm on VDE rise, lock the first qualified hit, report on VDE fall.
  // VDE fall is checked before qualification so a coinciding hit is a miss.
  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    trig_d   = trig_q;
    report_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hit_d  = 1'b0;
        trig_d = 1'b0;
        if (vde_rise_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (CE_PIX) begin
          trig_d = trig_q | trig_sync_s;
        end else begin
          trig_d = trig_q;
        end
        if (vde_fall_s) begin
          hit_d   = 1'b0;
          state_d = ST_REPORT;
        end else if (qualified_s) begin
          hit_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLD: begin
        if (CE_PIX) begin
          trig_d = trig_q | trig_sync_s;
        end else begin
          trig_d = trig_q;
        end
        if (vde_fall_s) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_REPORT: begin
        report_s = 1'b1;
        hit_d    = 1'b0;
        trig_d   = 1'b0;
        if (VDE) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        hit_d   = 1'b0;
        trig_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and per-frame flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      hit_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      trig_q  <= trig_d;
    end
  end

  // Candidate position: raster position at the first sample of each lit run.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cand_x_q <= {HCNT_W{1'b0}};
      cand_y_q <= {VCNT_W{1'b0}};
    end else if (run_start_s) begin
      cand_x_q <= hcnt_q;
      cand_y_q <= vcnt_q;
    end else begin
      cand_x_q <= cand_x_q;
      cand_y_q <= cand_y_q;
    end
  end

  // Delay compensation; a miss reports the origin.
  always_comb begin
    raw_x_s = {HCNT_W{1'b0}};
    raw_y_s = {VCNT_W{1'b0}};
    if (hit_q) begin
      raw_x_s = sat_sub_x(cand_x_q, SENSOR_DELAY);
      raw_y_s = sat_sub_y(cand_y_q, LINE_DELAY);
    end else begin
      raw_x_s = {HCNT_W{1'b0}};
      raw_y_s = {VCNT_W{1'b0}};
    end
  end

`ifdef LIGHTGUN_AVG_EN
  logic [HCNT_W-1:0] hist_x_q;
  logic [VCNT_W-1:0] hist_y_q;
  logic              hist_hit_q;

  // Previous frame's compensated position; a miss invalidates it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hist_x_q   <= {HCNT_W{1'b0}};
      hist_y_q   <= {VCNT_W{1'b0}};
      hist_hit_q <= 1'b0;
    end else if (report_s) begin
      hist_x_q   <= raw_x_s;
      hist_y_q   <= raw_y_s;
      hist_hit_q <= hit_q;
    end else begin
      hist_x_q   <= hist_x_q;
      hist_y_q   <= hist_y_q;
      hist_hit_q <= hist_hit_q;
    end
  end

  // Report record: average with the previous hit when there is one.
  always_comb begin
    rep_s.hit  = hit_q;
    rep_s.trig = trig_q | (CE_PIX & trig_sync_s);
    if (hit_q && hist_hit_q) begin
      rep_s.x = avg_x(raw_x_s, hist_x_q);
      rep_s.y = avg_y(raw_y_s, hist_y_q);
    end else begin
      rep_s.x = raw_x_s;
      rep_s.y = raw_y_s;
    end
  end
`else
  // Report record: raw per-frame compensated position.
  always_comb begin
    rep_s.x    = raw_x_s;
    rep_s.y    = raw_y_s;
    rep_s.hit  = hit_q;
    rep_s.trig = trig_q | (CE_PIX & trig_sync_s);
  end
`endif

  // A report may load only into an empty or simultaneously drained slot.
  assign load_s = report_s & (~valid_q | POS_READY);

  // Output slot, valid flag and overrun pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rep_q.x    <= {HCNT_W{1'b0}};
      rep_q.y    <= {VCNT_W{1'b0}};
      rep_q.hit  <= 1'b0;
      rep_q.trig <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (load_s) begin
        rep_q   <= rep_s;
        valid_q <= 1'b1;
      end else if (valid_q && POS_READY) begin
        rep_q   <= rep_q;
        valid_q <= 1'b0;
      end else begin
        rep_q   <= rep_q;
        valid_q <= valid_q;
      end
      overrun_q <= report_s & valid_q & ~POS_READY;
    end
  end

  assign POS_X     = rep_q.x;
  assign POS_Y     = rep_q.y;
  assign POS_HIT   = rep_q.hit;
  assign POS_TRIG  = rep_q.trig;
  assign POS_VALID = valid_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_lightgun_capture.sv
// tb_lightgun_capture: directed frames with hand-computed expected reports.
// One pixel = 4 CLK with CE_PIX on the 4th; inputs change on the falling
// edge at the start of each pixel, so synced SENSOR lines up with that pixel.
module tb_lightgun_capture;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CE_PIX, HDE, VDE, SENSOR, TRIGGER;
  logic [7:0] SENSOR_DELAY, LINE_DELAY;
  logic [9:0] POS_X;
  logic [8:0] POS_Y;
  logic       POS_HIT, POS_TRIG, POS_VALID, POS_READY, OVERRUN;

  int n_pass = 0;
  int n_chk  = 0;
  int last_x = 0;
  int last_y = 0;
  bit m_prev_hit = 1'b0;
  int m_prev_x = 0;
  int m_prev_y = 0;

  always #5 CLK = ~CLK;

  lightgun_capture #(.MIN_PULSE(2)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .CE_PIX       (CE_PIX),
    .HDE          (HDE),
    .VDE          (VDE),
    .SENSOR       (SENSOR),
    .TRIGGER      (TRIGGER),
    .SENSOR_DELAY (SENSOR_DELAY),
    .LINE_DELAY   (LINE_DELAY),
    .POS_X        (POS_X),
    .POS_Y        (POS_Y),
    .POS_HIT      (POS_HIT),
    .POS_TRIG     (POS_TRIG),
    .POS_VALID    (POS_VALID),
    .POS_READY    (POS_READY),
    .OVERRUN      (OVERRUN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One pixel period; entered and left just after a falling edge.
  task automatic pix(input bit h, input bit v, input bit s, input bit t);
    HDE = h; VDE = v; SENSOR = s; TRIGGER = t; CE_PIX = 1'b0;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    CE_PIX = 1'b1;
    @(posedge CLK); @(negedge CLK);
    CE_PIX = 1'b0;
  endtask

  task automatic line(input int npix, input int s_start, input int s_len,
                      input int glitch, input bit trg);
    for (int p = 0; p < npix; p++)
      pix(1'b1, 1'b1, ((p >= s_start) && (p < s_start + s_len)) || (p == glitch), trg);
    pix(1'b0, 1'b1, 1'b0, trg);
  endtask

  // Blanking, then nlines lines; the hit line is long with a 3-pixel pulse.
  task automatic frame(input int hit_line, input int hit_x, input int glitch_x,
                       input int nlines, input int trig_line);
    repeat (3) pix(1'b0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      if (l == hit_line) line(hit_x + 5, hit_x, 3, glitch_x, l == trig_line);
      else               line(1, -1, 0, -1, l == trig_line);
    end
  endtask

  // VDE fall, then check the report one CLK later against the model.
  task automatic end_frame(input string tag, input bit valid_pre, input int raw_x,
                           input int raw_y, input bit hit, input bit trig, input bit exp_ov);
    int ex, ey;
    ex = hit ? raw_x : 0;
    ey = hit ? raw_y : 0;
`ifdef LIGHTGUN_AVG_EN
    if (hit && m_prev_hit) begin
      ex = (raw_x + m_prev_x) >> 1;
      ey = (raw_y + m_prev_y) >> 1;
    end
    m_prev_hit = hit;
    m_prev_x   = raw_x;
    m_prev_y   = raw_y;
`endif
    pix(1'b0, 1'b0, 1'b0, 1'b0);
    chk($sformatf("%s.valid_at_fall", tag), POS_VALID, valid_pre);
    @(posedge CLK); @(negedge CLK);
    chk($sformatf("%s.valid", tag), POS_VALID, 1);
    chk($sformatf("%s.overrun", tag), OVERRUN, exp_ov);
    if (!exp_ov) begin
      chk($sformatf("%s.x", tag), POS_X, ex);
      chk($sformatf("%s.y", tag), POS_Y, ey);
      chk($sformatf("%s.hit", tag), POS_HIT, hit);
      chk($sformatf("%s.trig", tag), POS_TRIG, trig);
      last_x = ex;
      last_y = ey;
    end
  endtask

  task automatic consume(input string tag);
    POS_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    POS_READY = 1'b0;
    chk($sformatf("%s.drained", tag), POS_VALID, 0);
  endtask

  initial begin
    RESET_N = 1'b0; CE_PIX = 1'b0; HDE = 1'b0; VDE = 1'b0; SENSOR = 1'b0;
    TRIGGER = 1'b0; SENSOR_DELAY = 8'd0; LINE_DELAY = 8'd0; POS_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.x", POS_X, 0);
    chk("rst.y", POS_Y, 0);
    chk("rst.hit", POS_HIT, 0);
    chk("rst.trig", POS_TRIG, 0);
    chk("rst.valid", POS_VALID, 0);
    chk("rst.overrun", OVERRUN, 0);
    RESET_N = 1'b1;

    // Basic hit at (120,50).
    frame(50, 120, -1, 51, -1);
    end_frame("hit120", 1'b0, 120, 50, 1'b1, 1'b0, 1'b0);
    consume("hit120");

    // Miss with trigger mid-frame.
    frame(-1, 0, -1, 6, 3);
    end_frame("miss_trig", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    consume("miss_trig");

    // Glitch at 40, real pulse at (200,80).
    frame(80, 200, 40, 81, -1);
    end_frame("glitch", 1'b0, 200, 80, 1'b1, 1'b0, 1'b0);
    consume("glitch");

    // Delays: X clamps to 0, Y = 20-3.
    SENSOR_DELAY = 8'd10; LINE_DELAY = 8'd3;
    frame(20, 4, -1, 21, -1);
    end_frame("clampx", 1'b0, 0, 17, 1'b1, 1'b0, 1'b0);
    consume("clampx");

    // Delays: X = 30-10, Y clamps to 0.
    frame(2, 30, -1, 3, -1);
    end_frame("clampy", 1'b0, 20, 0, 1'b1, 1'b0, 1'b0);
    consume("clampy");
    SENSOR_DELAY = 8'd0; LINE_DELAY = 8'd0;

    // Overrun: consumer stalls across two frames.
    frame(5, 60, -1, 6, -1);
    end_frame("ovr_first", 1'b0, 60, 5, 1'b1, 1'b0, 1'b0);
    frame(7, 90, -1, 8, -1);
    end_frame("ovr_second", 1'b1, 90, 7, 1'b1, 1'b0, 1'b1);
    chk("ovr.kept_x", POS_X, last_x);
    chk("ovr.kept_y", POS_Y, last_y);
    @(posedge CLK); @(negedge CLK);
    chk("ovr.pulse_end", OVERRUN, 0);
    chk("ovr.still_valid", POS_VALID, 1);

    // Reset mid-frame: pending report dropped, partial frame ignored.
    repeat (3) pix(1'b0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 5; l++) line(1, -1, 0, -1, 1'b0);
    RESET_N = 1'b0;
    m_prev_hit = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("midrst.x", POS_X, 0);
    chk("midrst.y", POS_Y, 0);
    chk("midrst.hit", POS_HIT, 0);
    chk("midrst.trig", POS_TRIG, 0);
    chk("midrst.valid", POS_VALID, 0);
    chk("midrst.overrun", OVERRUN, 0);
    RESET_N = 1'b1;
    for (int l = 5; l < 10; l++) line(1, -1, 0, -1, 1'b0);
    line(35, 30, 3, -1, 1'b0);
    pix(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); @(negedge CLK);
    chk("midrst.no_report", POS_VALID, 0);
    chk("midrst.no_overrun", OVERRUN, 0);

    // Full frame after reset, then a second hit (averaged when enabled).
    frame(3, 100, -1, 4, -1);
    end_frame("post_rst", 1'b0, 100, 3, 1'b1, 1'b0, 1'b0);
    consume("post_rst");
    frame(4, 110, -1, 5, -1);
    end_frame("second_hit", 1'b0, 110, 4, 1'b1, 1'b0, 1'b0);
    consume("second_hit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lightgun_capture.md
# lightgun_capture

Console-side reader for the light-gun interface: it observes the same HDE/VDE/CE_PIX raster timing as the gun emulator and measures where the beam was when a light sensor fired. It synchronizes and deglitches SENSOR, latches the beam position of the first qualified hit per frame, and removes the sensor and line delays. Once per frame it presents a position report on a valid/ready handshake to the input-decode logic. The SENSOR source can be the gun emulator or a real gun.

## Interface

Parameters:
- MIN_PULSE, 2, number of consecutive CE_PIX samples with SENSOR high required to qualify a hit (1..15).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- CE_PIX  in  1  pixel clock enable
- HDE  in  1  horizontal display enable
- VDE  in  1  vertical display enable
- SENSOR  in  1  light sensor, asynchronous to CLK
- TRIGGER  in  1  gun trigger, asynchronous to CLK
- SENSOR_DELAY  in  8  pixel delay subtracted from the captured X
- LINE_DELAY  in  8  line delay subtracted from the captured Y
- POS_X  out  10  compensated hit column
- POS_Y  out  9  compensated hit line
- POS_HIT  out  1  1 = light seen this frame; 0 = miss
- POS_TRIG  out  1  trigger was high at any sample during the frame
- POS_VALID  out  1  report available
- POS_READY  in  1  consumer accepts the report
- OVERRUN  out  1  one-cycle pulse when a report is dropped

Clock and reset: one clock, CLK. RESET_N is asynchronous and active-low.

## Operation

- SENSOR and TRIGGER each pass through a 2-flop synchronizer on CLK. All other logic samples only on CE_PIX.
- Raster counters (CE_PIX only):
  - hcnt: 10 bits. Cleared while HDE is low; +1 while HDE is high; saturates at 1023.
  - vcnt: 9 bits. Cleared while VDE is low; +1 on each HDE falling edge while VDE is high; saturates at 511.
- FSM, encoded as an enum in the package:
  - IDLE: wait for a VDE rising edge, then go to ARMED. Clear the frame trigger flag.
  - ARMED: count consecutive samples where synced SENSOR, HDE and VDE are all high. The first sample of a run stores hcnt/vcnt as candidates. When the count reaches MIN_PULSE, go to HOLD with hit=1. A low sample before MIN_PULSE resets the count and discards the candidates. A VDE falling edge goes to REPORT with hit=0.
  - HOLD: ignore SENSOR. A VDE falling edge goes to REPORT.
  - REPORT (one cycle): build the report and go to ARMED if VDE is high, else IDLE.
- Compensation in REPORT:
  - POS_X = candidate X − SENSOR_DELAY, clamped at 0 on underflow.
  - POS_Y = candidate Y − LINE_DELAY, clamped at 0 on underflow.
  - On a miss, X and Y are reported as 0.
- POS_TRIG: OR of synced TRIGGER over all CE_PIX samples from ARMED entry through REPORT.
- Output handshake:
  - A report loads the outputs and sets POS_VALID when POS_VALID is 0, or when POS_VALID and POS_READY are both high in that same cycle.
  - Otherwise the new report is dropped, the old one is kept, and OVERRUN pulses for one cycle.
  - POS_VALID clears on POS_VALID & POS_READY.
  - POS_X, POS_Y, POS_HIT and POS_TRIG are stable while POS_VALID is high.

## Timing

- Reset values: POS_X=0, POS_Y=0, POS_HIT=0, POS_TRIG=0, POS_VALID=0, OVERRUN=0. FSM goes to IDLE; counters and synchronizers are cleared.
- Reset asserted mid-frame: the frame in progress is discarded. After release, no report is produced until a full VDE-rise to VDE-fall frame has been observed.
- Synchronizer latency is 2 CLK. The captured position is the hcnt/vcnt at the first CE_PIX sample of the qualifying run, after the synchronizer.
- POS_VALID rises 1 CLK after the CE_PIX sample that sees the VDE fall.
- Counters saturate and never wrap. A hit at saturated hcnt is reported as 1023 before compensation.
- If the VDE fall and the MIN_PULSE-th qualifying sample coincide, VDE wins: the frame is reported as a miss.

## Configuration

- LIGHTGUN_AVG_EN:
  - Defined: a hit report outputs the average of this frame's X/Y and the previous frame's X/Y, computed as (a+b)>>1, when the previous frame was also a hit. Otherwise the raw value is output. A miss clears the history.
  - Not defined: raw per-frame values, and no history registers.

## Structure

- lightgun_pkg holds the FSM state enum, the width constants HCNT_W=10 and VCNT_W=9, and the report struct (x, y, hit, trig).
- Sub-module lightgun_sensor_filter holds the synchronizer and the MIN_PULSE run counter. It outputs a qualified pulse and a run-start strobe.

## Test plan

- SENSOR high for 3 pixels from hcnt=120, vcnt=50, delays 0, MIN_PULSE=2 → POS_X=120, POS_Y=50, HIT=1.
- 1-pixel SENSOR glitch at hcnt=40, then a real pulse at hcnt=200, vcnt=80 → POS_X=200, POS_Y=80.
- No SENSOR in the frame, TRIGGER high mid-frame → HIT=0, X=Y=0, TRIG=1.
- SENSOR_DELAY=10 with a hit at hcnt=4 → POS_X=0 (clamped). LINE_DELAY=3 with a hit at vcnt=20 → POS_Y=17.
- POS_READY held low across two frames → first report stays, OVERRUN pulses once at the second frame end.
- RESET_N pulsed low mid-frame → all outputs 0; no report until the next full frame. With LIGHTGUN_AVG_EN, hits at X=100 then X=110 → second report X=105.
